// File: rtl/mc_controller.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute over a shared ALU and one memory port.
// Build option MEM_WAIT_EN: when defined, memory states wait for mem_ready; otherwise each access takes one cycle.
module mc_controller #(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         op,
    input  logic [5:0]         funct,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               mem_req,
    output logic               iord,
    output logic               irwrite,
    output logic               memwrite,
    output logic               pcen,
    output logic [1:0]         pcsrc,
    output logic               alusrca,
    output logic [1:0]         alusrcb,
    output logic [3:0]         alucontrol,
    output logic               regwrite,
    output logic               regdst,
    output logic               memtoreg,
    output logic               lbu,
    output logic               link,
    output logic               illegal,
    output logic [STATE_W-1:0] state
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_LBU   = 6'b100100;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_JR    = 6'b001000;
    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_SLT   = 6'b101010;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_RTEX   = 4'd6,
        S_RTWB   = 4'd7,
        S_BREX   = 4'd8,
        S_IMMEX  = 4'd9,
        S_IMMWB  = 4'd10,
        S_JEX    = 4'd11,
        S_JREX   = 4'd12
    } state_t;

    typedef struct packed {
        logic       mem_req;
        logic       iord;
        logic       irwrite;
        logic       memwrite;
        logic       pcwrite;
        logic       branch;
        logic [1:0] pcsrc;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [3:0] alucontrol;
        logic       regwrite;
        logic       regdst;
        logic       memtoreg;
        logic       lbu;
        logic       link;
        logic       illegal;
    } ctrl_t;

    state_t cur, nxt;
    ctrl_t  c;
    logic   rdy;
    logic   ne;

`ifdef MEM_WAIT_EN
    assign rdy = mem_ready;
`else
    logic unused_mem_ready;
    assign unused_mem_ready = mem_ready;
    assign rdy = 1'b1;
`endif

    assign ne = (op == OP_BNE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cur <= S_FETCH;
        else        cur <= nxt;
    end

    always_comb begin
        nxt = S_FETCH;
        c   = '0;
        case (cur)
            S_FETCH: begin
                c.mem_req    = 1'b1;
                c.alusrcb    = 2'b01;
                c.alucontrol = ALU_ADD;
                if (rdy) begin
                    c.irwrite = 1'b1;
                    c.pcwrite = 1'b1;
                    nxt       = S_DECODE;
                end else begin
                    nxt = S_FETCH;
                end
            end
            S_DECODE: begin
                // ALU precomputes the branch target while the opcode is decoded
                c.alusrcb    = 2'b11;
                c.alucontrol = ALU_ADD;
                case (op)
                    OP_LW, OP_LBU, OP_SW: nxt = S_MEMADR;
                    OP_RTYPE:             nxt = (funct == FN_JR) ? S_JREX : S_RTEX;
                    OP_BEQ, OP_BNE:       nxt = S_BREX;
                    OP_ADDI, OP_ORI:      nxt = S_IMMEX;
                    OP_J, OP_JAL:         nxt = S_JEX;
                    default: begin
                        c.illegal = 1'b1;
                        nxt       = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                c.alusrca    = 1'b1;
                c.alusrcb    = 2'b10;
                c.alucontrol = ALU_ADD;
                nxt          = (op == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                c.mem_req = 1'b1;
                c.iord    = 1'b1;
                nxt       = rdy ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                c.regwrite = 1'b1;
                c.memtoreg = 1'b1;
                c.lbu      = (op == OP_LBU);
                nxt        = S_FETCH;
            end
            S_MEMWR: begin
                c.mem_req  = 1'b1;
                c.iord     = 1'b1;
                c.memwrite = 1'b1;
                nxt        = rdy ? S_FETCH : S_MEMWR;
            end
            S_RTEX: begin
                c.alusrca = 1'b1;
                nxt       = S_RTWB;
                case (funct)
                    FN_ADD:  c.alucontrol = ALU_ADD;
                    FN_SUB:  c.alucontrol = ALU_SUB;
                    FN_AND:  c.alucontrol = ALU_AND;
                    FN_OR:   c.alucontrol = ALU_OR;
                    FN_SLT:  c.alucontrol = ALU_SLT;
                    default: begin
                        c.alucontrol = ALU_ADD;
                        c.illegal    = 1'b1;
                        nxt          = S_FETCH;
                    end
                endcase
            end
            S_RTWB: begin
                c.regwrite = 1'b1;
                c.regdst   = 1'b1;
                nxt        = S_FETCH;
            end
            S_BREX: begin
                c.alusrca    = 1'b1;
                c.alucontrol = ALU_SUB;
                c.pcsrc      = 2'b01;
                c.branch     = 1'b1;
                nxt          = S_FETCH;
            end
            S_IMMEX: begin
                c.alusrca    = 1'b1;
                c.alusrcb    = 2'b10;
                c.alucontrol = (op == OP_ORI) ? ALU_OR : ALU_ADD;
                nxt          = S_IMMWB;
            end
            S_IMMWB: begin
                c.regwrite = 1'b1;
                nxt        = S_FETCH;
            end
            S_JEX: begin
                c.pcsrc    = 2'b10;
                c.pcwrite  = 1'b1;
                c.link     = (op == OP_JAL);
                c.regwrite = (op == OP_JAL);
                nxt        = S_FETCH;
            end
            S_JREX: begin
                c.pcsrc   = 2'b11;
                c.pcwrite = 1'b1;
                nxt       = S_FETCH;
            end
            default: nxt = S_FETCH;
        endcase
    end

    // Reset forces a quiet control word so no enable can fire while the core is held
    always_comb begin
        mem_req    = c.mem_req;
        iord       = c.iord;
        irwrite    = c.irwrite;
        memwrite   = c.memwrite;
        pcen       = c.pcwrite | (c.branch & (zero ^ ne));
        pcsrc      = c.pcsrc;
        alusrca    = c.alusrca;
        alusrcb    = c.alusrcb;
        alucontrol = c.alucontrol;
        regwrite   = c.regwrite;
        regdst     = c.regdst;
        memtoreg   = c.memtoreg;
        lbu        = c.lbu;
        link       = c.link;
        illegal    = c.illegal;
        if (!reset) begin
            mem_req    = 1'b0;
            iord       = 1'b0;
            irwrite    = 1'b0;
            memwrite   = 1'b0;
            pcen       = 1'b0;
            pcsrc      = 2'b00;
            alusrca    = 1'b0;
            alusrcb    = 2'b00;
            alucontrol = ALU_ADD;
            regwrite   = 1'b0;
            regdst     = 1'b0;
            memtoreg   = 1'b0;
            lbu        = 1'b0;
            link       = 1'b0;
            illegal    = 1'b0;
        end
    end

    assign state = STATE_W'(cur);

endmodule

// File: tb/tb_mc_controller.sv
// Bench for mc_controller: route-table reference model checked every cycle, plus directed literal checks.
module tb_mc_controller;

    localparam logic [5:0] LW = 6'b100011, LBU = 6'b100100, SW = 6'b101011, RT = 6'b000000;
    localparam logic [5:0] BEQ = 6'b000100, BNE = 6'b000101, ADDI = 6'b001000, ORI = 6'b001101;
    localparam logic [5:0] JJ = 6'b000010, JAL = 6'b000011;
`ifdef MEM_WAIT_EN
    localparam int SW_HOLD = 4;
`else
    localparam int SW_HOLD = 1;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op, funct;
    logic       zero, mem_ready;
    logic       mem_req, iord, irwrite, memwrite, pcen, alusrca, regwrite, regdst, memtoreg, lbu, link, illegal;
    logic [1:0] pcsrc, alusrcb;
    logic [3:0] alucontrol;
    logic [3:0] state;

    mc_controller #(.STATE_W(4)) dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .iord(iord), .irwrite(irwrite), .memwrite(memwrite), .pcen(pcen),
        .pcsrc(pcsrc), .alusrca(alusrca), .alusrcb(alusrcb), .alucontrol(alucontrol),
        .regwrite(regwrite), .regdst(regdst), .memtoreg(memtoreg), .lbu(lbu), .link(link),
        .illegal(illegal), .state(state)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit done  = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic m_rdy;
`ifdef MEM_WAIT_EN
    assign m_rdy = mem_ready;
`else
    assign m_rdy = 1'b1;
`endif

    // Each instruction class walks a fixed route of states; the model just steps along it.
    function automatic int route_next(input logic [5:0] o, input logic [5:0] f, input int cur);
        int r[5];
        int n;
        r = '{0, 1, 0, 0, 0}; n = 2;
        case (o)
            LW, LBU:   begin r = '{0, 1, 2, 3, 4};  n = 5; end
            SW:        begin r = '{0, 1, 2, 5, 0};  n = 4; end
            RT: begin
                if (f == 6'b001000)
                    begin r = '{0, 1, 12, 0, 0}; n = 3; end
                else if (f inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010})
                    begin r = '{0, 1, 6, 7, 0};  n = 4; end
                else
                    begin r = '{0, 1, 6, 0, 0};  n = 3; end
            end
            BEQ, BNE:  begin r = '{0, 1, 8, 0, 0};  n = 3; end
            ADDI, ORI: begin r = '{0, 1, 9, 10, 0}; n = 4; end
            JJ, JAL:   begin r = '{0, 1, 11, 0, 0}; n = 3; end
            default:   begin r = '{0, 1, 0, 0, 0};  n = 2; end
        endcase
        for (int i = 0; i < n - 1; i++)
            if (r[i] == cur) return r[i + 1];
        return 0;
    endfunction

    // Control word expected in a given state; bit order matches dut_vec below.
    function automatic logic [19:0] exp_out(input int st, input logic [5:0] o, input logic [5:0] f,
                                            input logic z, input logic rdy);
        logic mr, io, irw, mw, pce, asel, rw, rd, m2r, lb, lk, ill;
        logic [1:0] ps, bsel;
        logic [3:0] alu;
        {mr, io, irw, mw, pce, asel, rw, rd, m2r, lb, lk, ill} = '0;
        ps = 2'b00; bsel = 2'b00; alu = 4'b0000;
        case (st)
            0:  begin mr = 1; bsel = 2'b01; alu = 4'b0010; irw = rdy; pce = rdy; end
            1:  begin bsel = 2'b11; alu = 4'b0010;
                      ill = !(o inside {LW, LBU, SW, RT, BEQ, BNE, ADDI, ORI, JJ, JAL}); end
            2:  begin asel = 1; bsel = 2'b10; alu = 4'b0010; end
            3:  begin mr = 1; io = 1; end
            4:  begin rw = 1; m2r = 1; lb = (o == LBU); end
            5:  begin mr = 1; io = 1; mw = 1; end
            6:  begin
                    asel = 1;
                    case (f)
                        6'b100000: alu = 4'b0010;
                        6'b100010: alu = 4'b0110;
                        6'b100100: alu = 4'b0000;
                        6'b100101: alu = 4'b0001;
                        6'b101010: alu = 4'b0111;
                        default:   begin alu = 4'b0010; ill = 1; end
                    endcase
                end
            7:  begin rw = 1; rd = 1; end
            8:  begin asel = 1; alu = 4'b0110; ps = 2'b01; pce = (o == BNE) ? !z : z; end
            9:  begin asel = 1; bsel = 2'b10; alu = (o == ORI) ? 4'b0001 : 4'b0010; end
            10: rw = 1;
            11: begin ps = 2'b10; pce = 1; lk = (o == JAL); rw = (o == JAL); end
            12: begin ps = 2'b11; pce = 1; end
            default: ;
        endcase
        return {mr, io, irw, mw, pce, ps, asel, bsel, alu, rw, rd, m2r, lb, lk, ill};
    endfunction

    int exp_state = 0;
    always @(posedge clk or negedge reset) begin
        if (!reset)
            exp_state <= 0;
        else if ((exp_state == 0 || exp_state == 3 || exp_state == 5) && !m_rdy)
            exp_state <= exp_state;
        else
            exp_state <= route_next(op, funct, exp_state);
    end

    // Per-cycle compare against the model
    initial begin
        logic [19:0] dv, ev;
        while (!done) begin
            @(negedge clk);
            #1;
            if (done) break;
            dv = {mem_req, iord, irwrite, memwrite, pcen, pcsrc, alusrca, alusrcb, alucontrol,
                  regwrite, regdst, memtoreg, lbu, link, illegal};
            ev = !reset ? {10'b0, 4'b0010, 6'b0} : exp_out(exp_state, op, funct, zero, m_rdy);
            chk("outputs", 32'(dv), 32'(ev));
            chk("state", 32'(state), 32'(exp_state));
        end
    end

    // ---------------- directed stimulus ----------------
    logic [31:0] tcode;
    logic [15:0] rw_mask, m2r_mask, rd_mask;
    int          c_mw, c_ill, c_lbu;
    logic        pcen_br, pcen_j, link_j;
    logic [1:0]  psrc_j;
    logic [3:0]  alu_ex;

    task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input logic z,
                             input int st_stall, input int n_stall, output int cyc);
        int k, stalled;
        bit fin;
        k = 0;
        while (state != 4'd0 && k < 50) begin @(negedge clk); k++; end
        if (k >= 50) chk("fetch_wait_timeout", 1, 0);
        op = o; funct = f; zero = z;
        cyc = 0; stalled = 0; fin = 0;
        tcode = 0; rw_mask = 0; m2r_mask = 0; rd_mask = 0;
        c_mw = 0; c_ill = 0; c_lbu = 0;
        pcen_br = 0; pcen_j = 0; link_j = 0; psrc_j = 0; alu_ex = 0;
        for (int i = 0; i < 60 && !fin; i++) begin
            if (int'(state) == st_stall && stalled < n_stall) begin
                mem_ready = 1'b0; stalled++;
            end else begin
                mem_ready = 1'b1;
            end
            #1;
            tcode = {tcode[27:0], state};
            if (regwrite) rw_mask[state]  = 1'b1;
            if (memtoreg) m2r_mask[state] = 1'b1;
            if (regdst)   rd_mask[state]  = 1'b1;
            c_mw  += int'(memwrite);
            c_ill += int'(illegal);
            c_lbu += int'(lbu);
            if (state == 4'd8) pcen_br = pcen;
            if (state == 4'd6 || state == 4'd9) alu_ex = alucontrol;
            if (state == 4'd11 || state == 4'd12) begin pcen_j = pcen; psrc_j = pcsrc; link_j = link; end
            cyc++;
            @(negedge clk);
            if (state == 4'd0) fin = 1;
        end
        if (!fin) chk("instr_timeout", 1, 0);
    endtask

    initial begin
        int cyc, k;
        logic [5:0] fn_tab [5];
        logic [3:0] alu_tab[5];
        fn_tab  = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
        alu_tab = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b0111};

        reset = 1'b1; op = 0; funct = 0; zero = 0; mem_ready = 1'b1;
        #2 reset = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_state", 32'(state), 0);
        chk("rst_mem_req", 32'(mem_req), 0);
        chk("rst_alucontrol", 32'(alucontrol), 32'h2);
        chk("rst_enables", 32'({regwrite, memwrite, pcen, irwrite}), 0);
        @(negedge clk);
        reset = 1'b1;

        run_instr(LW, 6'd0, 1'b0, -1, 0, cyc);
        chk("lw_cycles", cyc, 5);
        chk("lw_trace", tcode, 32'h01234);
        chk("lw_regwrite_states", 32'(rw_mask), 32'h0010);
        chk("lw_memtoreg_states", 32'(m2r_mask), 32'h0010);
        chk("lw_lbu", c_lbu, 0);

        run_instr(LBU, 6'd0, 1'b0, -1, 0, cyc);
        chk("lbu_cycles", cyc, 5);
        chk("lbu_flag", c_lbu, 1);

        run_instr(BEQ, 6'd0, 1'b1, -1, 0, cyc);
        chk("beq_cycles", cyc, 3);
        chk("beq_trace", tcode, 32'h018);
        chk("beq_z1_pcen", 32'(pcen_br), 1);
        run_instr(BNE, 6'd0, 1'b1, -1, 0, cyc);
        chk("bne_z1_pcen", 32'(pcen_br), 0);
        run_instr(BEQ, 6'd0, 1'b0, -1, 0, cyc);
        chk("beq_z0_pcen", 32'(pcen_br), 0);
        run_instr(BNE, 6'd0, 1'b0, -1, 0, cyc);
        chk("bne_z0_pcen", 32'(pcen_br), 1);

        run_instr(SW, 6'd0, 1'b0, 5, 3, cyc);
        chk("sw_memwrite_cycles", c_mw, SW_HOLD);
        chk("sw_cycles", cyc, 3 + SW_HOLD);
        chk("sw_regwrite", 32'(rw_mask), 0);

        for (int i = 0; i < 5; i++) begin
            run_instr(RT, fn_tab[i], 1'b0, -1, 0, cyc);
            chk("rtype_alucontrol", 32'(alu_ex), 32'(alu_tab[i]));
            chk("rtype_cycles", cyc, 4);
        end
        chk("slt_trace", tcode, 32'h0167);
        chk("slt_regwrite_states", 32'(rw_mask), 32'h0080);
        chk("slt_regdst_states", 32'(rd_mask), 32'h0080);

        run_instr(RT, 6'b000000, 1'b0, -1, 0, cyc);
        chk("badfunct_illegal", c_ill, 1);
        chk("badfunct_regwrite", 32'(rw_mask), 0);
        chk("badfunct_cycles", cyc, 3);

        run_instr(6'b111111, 6'd0, 1'b0, -1, 0, cyc);
        chk("badop_illegal", c_ill, 1);
        chk("badop_trace", tcode, 32'h01);

        run_instr(JAL, 6'd0, 1'b0, -1, 0, cyc);
        chk("jal_cycles", cyc, 3);
        chk("jal_pcsrc", 32'(psrc_j), 2);
        chk("jal_pcen", 32'(pcen_j), 1);
        chk("jal_link", 32'(link_j), 1);
        chk("jal_regwrite_states", 32'(rw_mask), 32'h0800);
        run_instr(JJ, 6'd0, 1'b0, -1, 0, cyc);
        chk("j_link", 32'(link_j), 0);
        chk("j_regwrite", 32'(rw_mask), 0);
        run_instr(RT, 6'b001000, 1'b0, -1, 0, cyc);
        chk("jr_trace", tcode, 32'h01C);
        chk("jr_pcsrc", 32'(psrc_j), 3);

        run_instr(ADDI, 6'd0, 1'b0, -1, 0, cyc);
        chk("addi_alu", 32'(alu_ex), 32'h2);
        chk("addi_regwrite_states", 32'(rw_mask), 32'h0400);
        chk("addi_cycles", cyc, 4);
        run_instr(ORI, 6'd0, 1'b0, -1, 0, cyc);
        chk("ori_alu", 32'(alu_ex), 32'h1);

        // reset pulled while the load is in MEMRD
        op = LW; funct = 0; mem_ready = 1'b1;
        k = 0;
        while (state != 4'd3 && k < 20) begin @(negedge clk); k++; end
        chk("reach_memrd", 32'(state), 3);
        reset = 1'b0;
        #1;
        chk("abort_state", 32'(state), 0);
        chk("abort_enables", 32'({regwrite, memtoreg, memwrite, mem_req}), 0);
        @(negedge clk);
        #1;
        chk("abort_hold_enables", 32'({regwrite, memwrite, pcen, irwrite}), 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        #1;
        chk("first_fetch_after_reset", 32'(state), 1);

        repeat (6) @(negedge clk);
        done = 1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mc_controller.md
Name: mc_controller

Overview:
- Multicycle control FSM for the MIPS core: one instruction takes 3–5 cycles over a shared ALU and a single unified memory port.
- Decodes op/funct and drives all datapath selects, write enables and alucontrol per state.
- Supports variable-latency memory through a req/ready handshake.
- Sits beside the multicycle datapath, in the same role as the single-cycle controller.

Parameters:
- STATE_W, 4, width of the exported state register.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- op  in  6  instr[31:26] from the instruction register.
- funct  in  6  instr[5:0] from the instruction register.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes the current access this cycle.
- mem_req  out  1  memory access request.
- iord  out  1  address select: 0=PC, 1=ALUOut.
- irwrite  out  1  load instruction register.
- memwrite  out  1  memory write.
- pcen  out  1  PC load enable.
- pcsrc  out  2  PC source: 00=ALU result, 01=ALUOut, 10=jump target, 11=rs.
- alusrca  out  1  ALU A select: 0=PC, 1=rs.
- alusrcb  out  2  ALU B select: 00=rt, 01=4, 10=signext imm, 11=imm<<2.
- alucontrol  out  4  ALU operation: 0000 and, 0001 or, 0010 add, 0110 sub, 0111 slt.
- regwrite  out  1  register file write.
- regdst  out  1  write register: 1=rd, 0=rt.
- memtoreg  out  1  writeback from memory data.
- lbu  out  1  zero-extended byte load select.
- link  out  1  write PC to $31 (jal).
- illegal  out  1  one-cycle pulse on an unsupported opcode/funct.
- state  out  STATE_W  current state, for debug.

Behaviour:
- States: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTEX=6, RTWB=7, BREX=8, IMMEX=9, IMMWB=10, JEX=11, JREX=12. Codes 13–15 go to FETCH on the next clock.
- Reset low: state=FETCH asynchronously. While reset is low, every output is 0 and alucontrol=0010.
- Outputs are Moore, decoded from state, except mem_ready-qualified enables and the pcen branch term. Any output not listed for a state is 0.
- pcen = pcwrite | (branch & (zero ^ ne)), where ne = (op==000101).
- FETCH: mem_req=1, iord=0, alusrca=0, alusrcb=01, alucontrol=add, pcsrc=00.
  - mem_ready=1: irwrite=1, pcwrite=1, next state DECODE.
  - mem_ready=0: stay in FETCH.
- DECODE: alusrca=0, alusrcb=11, add (precomputes the branch target). Next state by op:
  - 100011 (lw), 100100 (lbu), 101011 (sw) → MEMADR.
  - 000000, funct=001000 (jr) → JREX; any other funct → RTEX.
  - 000100 (beq), 000101 (bne) → BREX.
  - 001000 (addi), 001101 (ori) → IMMEX.
  - 000010 (j), 000011 (jal) → JEX.
  - Any other op → FETCH with illegal=1.
- MEMADR: alusrca=1, alusrcb=10, add. Next state MEMWR for sw, else MEMRD.
- MEMRD: mem_req=1, iord=1. Wait for mem_ready, then MEMWB.
- MEMWB: regwrite=1, memtoreg=1, regdst=0, lbu=(op==100100). Next state FETCH.
- MEMWR: mem_req=1, iord=1, memwrite=1. Held until mem_ready, then FETCH.
- RTEX: alusrca=1, alusrcb=00. alucontrol from funct:
  - 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt.
  - Other funct: alucontrol=add, illegal=1, next state FETCH with no writeback.
  - Legal funct: next state RTWB.
- RTWB: regwrite=1, regdst=1, memtoreg=0. Next state FETCH.
- BREX: alusrca=1, alusrcb=00, sub, pcsrc=01, branch=1. Next state FETCH.
- IMMEX: alusrca=1, alusrcb=10; add for addi, or for ori. Next state IMMWB.
- IMMWB: regwrite=1, regdst=0. Next state FETCH.
- JEX: pcsrc=10, pcwrite=1. For jal also link=1 and regwrite=1. Next state FETCH.
- JREX: pcsrc=11, pcwrite=1. Next state FETCH.
- Latencies with mem_ready held at 1:
  - j, jr, beq, bne: 3 cycles.
  - R-type, addi, ori, sw: 4 cycles.
  - lw, lbu: 5 cycles.
- Reset asserted mid-instruction aborts it; no write enable is asserted after reset falls.

Optional Feature:
- Macro MEM_WAIT_EN.
- Defined: mem_ready is honoured as described above.
- Undefined: mem_ready is ignored and treated as 1, so every memory state lasts exactly one cycle. mem_req is still driven.

Test Plan:
- Reset low mid-MEMRD, then release → state=0, all enables 0 during reset; first fetch starts on the next edge.
- lw (op=100011), mem_ready=1 → state sequence 0,1,2,3,4,0; regwrite=1 and memtoreg=1 only in state 4.
- beq then bne with zero=1 → beq: pcen=1 in BREX; bne: pcen=0 in BREX.
- sw with mem_ready low for 3 cycles in MEMWR (MEM_WAIT_EN defined) → memwrite=1 for 4 cycles, then FETCH.
- R-type funct=101010 → alucontrol=0111 in RTEX; regwrite=1, regdst=1 in RTWB. funct=000000 → illegal=1, no regwrite.
- op=111111 → DECODE→FETCH, illegal=1 for exactly one cycle. jal (op=000011) → JEX with pcsrc=10, pcen=1, link=1, regwrite=1.
